// File: rtl/tl_peri_slave.sv
// tl_peri_slave: TileLink-UL responder over a DEPTH-word byte-writable window at BASE_ADDR.
// Ports: clk/reset, channel A (a_*), channel D (d_*). Optional TL_PERI_SLAVE_WAIT_EN adds LATENCY wait cycles.
module tl_peri_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int DEPTH        = 64,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic                    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic                    d_source,
  output logic                    d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int LG    = $clog2(MASK_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] WIN =
    (ADDR_WIDTH+1)'(DEPTH * MASK_WIDTH);
  localparam logic [SIZE_WIDTH-1:0] MAX_SIZE = SIZE_WIDTH'(LG);

`ifdef TL_PERI_SLAVE_WAIT_EN
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  logic [CW-1:0] cnt;
`else
  typedef enum logic [1:0] {IDLE, RESP} state_t;
  localparam int unused_lat = LATENCY;
`endif

  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic is_get, is_put, err, accept;
  logic unused_ok;

  assign offset     = a_address - BASE_ADDR;
  assign align_mask = ~({ADDR_WIDTH{1'b1}} << a_size);
  assign idx        = offset[LG +: IDX_W];
  assign is_get     = a_opcode == OPCODE_WIDTH'(4);
  assign is_put     = a_opcode == OPCODE_WIDTH'(0)
                   || a_opcode == OPCODE_WIDTH'(1);
  assign err        = (a_address < BASE_ADDR)
                   || ({1'b0, offset} >= WIN)
                   || (a_size > MAX_SIZE)
                   || ((a_address & align_mask) != '0)
                   || !(is_get || is_put);
  assign rd_word    = (int'(idx) < DEPTH) ? mem[idx] : '0;
  assign accept     = (state == IDLE) && a_valid && a_ready;
  assign d_param    = '0;
  assign d_sink     = 1'b0;
  assign unused_ok  = ^{a_param, offset};

  // Writes commit on the acceptance edge so a following Get sees them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (accept && is_put && !err) begin
      for (int i = 0; i < MASK_WIDTH; i++)
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_ready  <= 1'b0;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= 1'b0;
      d_data   <= '0;
      d_error  <= 1'b0;
`ifdef TL_PERI_SLAVE_WAIT_EN
      cnt      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (a_valid && a_ready) begin
            a_ready  <= 1'b0;
            d_opcode <= is_get ? OPCODE_WIDTH'(1) : '0;
            d_size   <= a_size;
            d_source <= a_source;
            d_error  <= err;
            d_data   <= (is_get && !err) ? rd_word : '0;
`ifdef TL_PERI_SLAVE_WAIT_EN
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end else begin
              state   <= RESP;
              d_valid <= 1'b1;
            end
`else
            state   <= RESP;
            d_valid <= 1'b1;
`endif
          end else begin
            a_ready <= 1'b1;
          end
        end
`ifdef TL_PERI_SLAVE_WAIT_EN
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            d_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        RESP: begin
          if (d_ready) begin
            d_valid <= 1'b0;
            a_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_peri_slave.sv
// tb_tl_peri_slave: directed self-checking bench for tl_peri_slave.
// Drives and samples on the falling edge; expectations are hand-computed.
module tb_tl_peri_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [2:0]  a_size = '0;
  logic        a_source = 1'b0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [2:0]  d_size;
  logic        d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int checks = 0;
  int errors = 0;

  logic [2:0]  r_opcode;
  logic [2:0]  r_size;
  logic        r_source;
  logic [31:0] r_data;
  logic        r_error;

  tl_peri_slave dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error)
  );

  always #5 clk = ~clk;

  // Present one request; returns at the falling edge after acceptance.
  task automatic send(input logic [2:0] op, input logic [2:0] sz,
                      input logic src, input logic [31:0] addr,
                      input logic [3:0] msk, input logic [31:0] dat);
    int n = 0;
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: a_ready=%b required 1", a_ready);
    end
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = msk; a_data = dat;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // Wait for d_valid, capture fields, then complete the handshake.
  task automatic get_resp();
    int n = 0;
    while (!d_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (d_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: d_valid=%b required 1", d_valid);
    end
    r_opcode = d_opcode; r_size = d_size; r_source = d_source;
    r_data = d_data; r_error = d_error;
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({a_ready, d_valid, d_error, d_opcode, d_param, d_size,
         d_source, d_sink, d_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a_ready=%b d_valid=%b d_data=%h required all 0",
               a_ready, d_valid, d_data);
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: a_ready=%b required 0", a_ready);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_aready: a_ready=%b required 1", a_ready);
    end
  endtask

  task automatic test_write_read();
    send(3'd0, 3'd2, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
    get_resp();
    checks++;
    if (r_opcode !== 3'd0 || r_source !== 1'b1 || r_error !== 1'b0
        || r_size !== 3'd2 || r_data !== 32'h0) begin
      errors++;
      $display("FAIL put_ack: op=%0d src=%b err=%b size=%0d data=%h required 0 1 0 2 0",
               r_opcode, r_source, r_error, r_size, r_data);
    end
    send(3'd4, 3'd2, 1'b0, 32'h8, 4'hF, 32'h0);
    get_resp();
    checks++;
    if (r_opcode !== 3'd1 || r_data !== 32'hDEADBEEF || r_error !== 1'b0
        || r_source !== 1'b0) begin
      errors++;
      $display("FAIL get_data: op=%0d data=%h err=%b required 1 deadbeef 0",
               r_opcode, r_data, r_error);
    end
  endtask

  task automatic test_partial();
    send(3'd1, 3'd2, 1'b0, 32'h8, 4'h5, 32'h11223344);
    get_resp();
    checks++;
    if (r_opcode !== 3'd0 || r_error !== 1'b0) begin
      errors++;
      $display("FAIL partial_ack: op=%0d err=%b required 0 0", r_opcode, r_error);
    end
    send(3'd4, 3'd2, 1'b0, 32'h8, 4'hF, 32'h0);
    get_resp();
    checks++;
    if (r_data !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL partial_data: data=%h required de22be44", r_data);
    end
  endtask

  task automatic test_errors();
    send(3'd4, 3'd2, 1'b0, 32'h100, 4'hF, 32'h0);
    get_resp();
    checks++;
    if (r_error !== 1'b1 || r_data !== 32'h0 || r_opcode !== 3'd1) begin
      errors++;
      $display("FAIL err_range: err=%b data=%h op=%0d required 1 0 1",
               r_error, r_data, r_opcode);
    end
    send(3'd0, 3'd2, 1'b0, 32'h102, 4'hF, 32'h55555555);
    get_resp();
    checks++;
    if (r_error !== 1'b1 || r_opcode !== 3'd0) begin
      errors++;
      $display("FAIL err_misalign: err=%b op=%0d required 1 0", r_error, r_opcode);
    end
    send(3'd0, 3'd2, 1'b0, 32'h6, 4'hF, 32'h66666666);
    get_resp();
    checks++;
    if (r_error !== 1'b1) begin
      errors++;
      $display("FAIL err_misalign_in: err=%b required 1", r_error);
    end
    send(3'd2, 3'd2, 1'b0, 32'h0, 4'hF, 32'h77777777);
    get_resp();
    checks++;
    if (r_error !== 1'b1 || r_opcode !== 3'd0) begin
      errors++;
      $display("FAIL err_opcode: err=%b op=%0d required 1 0", r_error, r_opcode);
    end
    send(3'd4, 3'd3, 1'b0, 32'h0, 4'hF, 32'h0);
    get_resp();
    checks++;
    if (r_error !== 1'b1 || r_data !== 32'h0) begin
      errors++;
      $display("FAIL err_size: err=%b data=%h required 1 0", r_error, r_data);
    end
    send(3'd4, 3'd2, 1'b0, 32'h4, 4'hF, 32'h0);
    get_resp();
    checks++;
    if (r_data !== 32'h0 || r_error !== 1'b0) begin
      errors++;
      $display("FAIL err_nowrite4: data=%h err=%b required 0 0", r_data, r_error);
    end
    send(3'd4, 3'd2, 1'b0, 32'h0, 4'hF, 32'h0);
    get_resp();
    checks++;
    if (r_data !== 32'h0) begin
      errors++;
      $display("FAIL err_nowrite0: data=%h required 0", r_data);
    end
    send(3'd4, 3'd0, 1'b0, 32'h9, 4'h2, 32'h0);
    get_resp();
    checks++;
    if (r_error !== 1'b0 || r_data !== 32'hDE22BE44 || r_size !== 3'd0) begin
      errors++;
      $display("FAIL byte_get: err=%b data=%h size=%0d required 0 de22be44 0",
               r_error, r_data, r_size);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold;
    send(3'd4, 3'd2, 1'b1, 32'h8, 4'hF, 32'h0);
    hold = {d_valid, d_opcode, d_size, d_source, d_error, 21'h0} ^ d_data;
    checks++;
    if (d_valid !== 1'b1 || d_data !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL bp_first: d_valid=%b data=%h required 1 de22be44", d_valid, d_data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (d_valid !== 1'b1 || a_ready !== 1'b0 || d_data !== 32'hDE22BE44
          || d_opcode !== 3'd1 || d_source !== 1'b1 || d_size !== 3'd2
          || d_error !== 1'b0
          || (({d_valid, d_opcode, d_size, d_source, d_error, 21'h0} ^ d_data) !== hold)) begin
        errors++;
        $display("FAIL bp_hold%0d: d_valid=%b a_ready=%b data=%h op=%0d src=%b required 1 0 de22be44 1 1",
                 i, d_valid, a_ready, d_data, d_opcode, d_source);
      end
    end
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    checks++;
    if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: d_valid=%b a_ready=%b required 0 1", d_valid, a_ready);
    end
  endtask

  task automatic test_back_to_back();
    d_ready = 1'b1;
    send(3'd0, 3'd2, 1'b0, 32'hFC, 4'hF, 32'hCAFEF00D);
    checks++;
    if (d_valid !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resp: d_valid=%b a_ready=%b required 1 0", d_valid, a_ready);
    end
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_turn: d_valid=%b a_ready=%b required 0 1", d_valid, a_ready);
    end
    send(3'd4, 3'd2, 1'b0, 32'hFC, 4'hF, 32'h0);
    checks++;
    if (d_valid !== 1'b1 || d_data !== 32'hCAFEF00D || d_error !== 1'b0) begin
      errors++;
      $display("FAIL b2b_get: d_valid=%b data=%h err=%b required 1 cafef00d 0",
               d_valid, d_data, d_error);
    end
    @(negedge clk);
    d_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(3'd0, 3'd2, 1'b0, 32'h8, 4'hF, 32'h12345678);
    checks++;
    if (d_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending: d_valid=%b required 1", d_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (d_valid !== 1'b0 || a_ready !== 1'b0 || d_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_async: d_valid=%b a_ready=%b data=%h required 0 0 0",
               d_valid, a_ready, d_data);
    end
    @(negedge clk);
    reset = 1'b0;
    d_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: a_ready=%b d_valid=%b required 1 0", a_ready, d_valid);
    end
    d_ready = 1'b0;
    send(3'd4, 3'd2, 1'b0, 32'h8, 4'hF, 32'h0);
    get_resp();
    checks++;
    if (r_data !== 32'h0 || r_error !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared: data=%h err=%b required 0 0", r_data, r_error);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
